io_port_responder: RTL and testbench

Memory-mapped I/O responder sitting on the MIPS data-memory bus beside the RAM. It decodes processor loads and stores in a 16-byte window and drives the 32-bit `PortOut` register. It samples the 8-bit `PortIn` through a synchronizer and records input changes in a sticky flag and a saturating counter. The top level uses `Hit` to select `ReadData` from this block instead of RAM, and may route `Irq` to a future interrupt input.

---
 rtl/io_port_responder.sv | 111 +++++++++++
 tb/tb_io_port_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder on the data-memory bus: a 16-byte window holding an
// output register, a synchronized input port, a sticky change flag and a change counter.
module io_port_responder #(
    parameter logic [31:0] BASE_ADDRESS     = 32'h1001_0000,
    parameter int          EDGE_COUNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        Irq
);

    localparam logic [1:0] OFS_OUT  = 2'd0;
    localparam logic [1:0] OFS_IN   = 2'd1;
    localparam logic [1:0] OFS_STAT = 2'd2;
    localparam logic [1:0] OFS_ECNT = 2'd3;

    logic [31:0]                 port_out_q;
    logic [7:0]                  sync1;
    logic [7:0]                  sync2;
    logic [7:0]                  prev;
    logic                        chg_flag;
    logic                        irq_en;
    logic [EDGE_COUNT_WIDTH-1:0] cnt;
    logic [EDGE_COUNT_WIDTH-1:0] cnt_base;
    logic [EDGE_COUNT_WIDTH-1:0] cnt_next;
    logic [31:0]                 cnt_ext;
    logic [1:0]                  offset;
    logic                        wr;
    logic                        wr_out;
    logic                        wr_stat;
    logic                        wr_ecnt;
    logic                        change;

    // Bus: no handshake; every hit access completes in the cycle it is presented,
    // writes land on the rising edge and reads are purely combinational.
    assign Hit     = (Address[31:4] == BASE_ADDRESS[31:4]);
    assign offset  = Address[3:2];
    assign wr      = MemWrite & Hit;
    assign wr_out  = wr && (offset == OFS_OUT);
    assign wr_stat = wr && (offset == OFS_STAT);
    assign wr_ecnt = wr && (offset == OFS_ECNT);
    assign change  = (sync2 != prev);

    // Clear happens before the increment, so a clear coinciding with a change yields 1.
    always_comb begin
        cnt_base = wr_ecnt ? '0 : cnt;
        cnt_next = cnt_base;
        if (change && (cnt_base != '1)) begin
            cnt_next = cnt_base + 1'b1;
        end
    end

    always_comb begin
        cnt_ext = '0;
        cnt_ext[EDGE_COUNT_WIDTH-1:0] = cnt;
    end

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && Hit) begin
            case (offset)
                OFS_OUT:  ReadData = port_out_q;
                OFS_IN:   ReadData = {24'h0, sync2};
                OFS_STAT: ReadData = {23'h0, irq_en, 7'h0, chg_flag};
                OFS_ECNT: ReadData = cnt_ext;
                default:  ReadData = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= 32'h0;
            sync1      <= 8'h0;
            sync2      <= 8'h0;
            prev       <= 8'h0;
            chg_flag   <= 1'b0;
            irq_en     <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
            if (wr_out) begin
                port_out_q <= WriteData;
            end
            // A new change takes priority over a write-1-to-clear in the same cycle.
            if (change) begin
                chg_flag <= 1'b1;
            end else if (wr_stat && WriteData[0]) begin
                chg_flag <= 1'b0;
            end
            if (wr_stat) begin
                irq_en <= WriteData[8];
            end
            cnt <= cnt_next;
        end
    end

    assign PortOut = port_out_q;
    assign Irq     = chg_flag & irq_en;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: a vector table for the register map and
// hand-written sequences for synchronizer timing, simultaneous events, saturation and reset.
module tb_io_port_responder;

    localparam logic [31:0] B = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] read_data;
    logic        hit;
    logic [31:0] port_out;
    logic        irq;
    logic [31:0] read_data4;
    logic        hit4;
    logic [31:0] port_out4;
    logic        irq4;

    int tests_run;
    int tests_failed;

    io_port_responder dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .ReadData(read_data), .Hit(hit), .PortOut(port_out), .Irq(irq)
    );

    io_port_responder #(.EDGE_COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .ReadData(read_data4), .Hit(hit4), .PortOut(port_out4), .Irq(irq4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  pin;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [31:0] exp_pout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance past the next rising edge, then drop the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick();
    endtask

    // Presents a load and waits to the falling edge; caller checks, then calls tick().
    task automatic start_read(input logic [31:0] addr);
        Address  = addr;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        start_read(addr);
        check(name, read_data, exp);
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;

        //            name          pin    addr              wdata          we    re    exp_rd         hit   pout           irq
        vecs[0]  = '{"rd_out_rst",  8'h00, B,                32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[1]  = '{"rd_in_rst",   8'h00, B + 32'h4,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[2]  = '{"rd_stat_rst", 8'h00, B + 32'h8,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[3]  = '{"rd_ecnt_rst", 8'h00, B + 32'hC,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[4]  = '{"miss_ram",    8'h00, 32'h1000_0000,    32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[5]  = '{"wr_out",      8'h00, B,                32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[6]  = '{"rd_out",      8'h00, B,                32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{"wr_in_ro",    8'h00, B + 32'h4,        32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{"rd_out_keep", 8'h00, B,                32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{"rdwr_out",    8'h00, B,                32'hCAFE_0001, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{"rd_out_new",  8'h00, B,                32'h0,         1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b0};
        vecs[11] = '{"in_edge0",    8'h5A, B + 32'h4,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[12] = '{"in_edge1",    8'h5A, B + 32'h4,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[13] = '{"in_edge2",    8'h5A, B + 32'h4,        32'h0,         1'b0, 1'b1, 32'h5A,        1'b1, 32'hCAFE_0001, 1'b0};
        vecs[14] = '{"stat_edge3",  8'h5A, B + 32'h8,        32'h0,         1'b0, 1'b1, 32'h1,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[15] = '{"ecnt_one",    8'h5A, B + 32'hC,        32'h0,         1'b0, 1'b1, 32'h1,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[16] = '{"rd_lowbits",  8'h5A, B + 32'h3,        32'h0,         1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b0};
        vecs[17] = '{"wr_irq_en",   8'h5A, B + 32'h8,        32'h100,       1'b1, 1'b0, 32'h0,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[18] = '{"rd_stat_irq", 8'h5A, B + 32'h8,        32'h0,         1'b0, 1'b1, 32'h101,       1'b1, 32'hCAFE_0001, 1'b1};
        vecs[19] = '{"w1c_stat",    8'h5A, B + 32'h8,        32'h1,         1'b1, 1'b0, 32'h0,         1'b1, 32'hCAFE_0001, 1'b1};
        vecs[20] = '{"rd_stat_clr", 8'h5A, B + 32'h8,        32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'hCAFE_0001, 1'b0};
        vecs[21] = '{"miss_above",  8'h5A, B + 32'h10,       32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'hCAFE_0001, 1'b0};

        // Reset asserted mid-cycle with the port idle.
        #3 reset = 1'b0;
        @(negedge clk);
        check("rst_portout", port_out, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            PortIn    = vecs[i].pin;
            Address   = vecs[i].addr;
            WriteData = vecs[i].wdata;
            MemWrite  = vecs[i].we;
            MemRead   = vecs[i].re;
            @(negedge clk);
            check({vecs[i].name, "_rd"},   read_data, vecs[i].exp_rd);
            check({vecs[i].name, "_hit"},  {31'h0, hit}, {31'h0, vecs[i].exp_hit});
            check({vecs[i].name, "_pout"}, port_out, vecs[i].exp_pout);
            check({vecs[i].name, "_irq"},  {31'h0, irq}, {31'h0, vecs[i].exp_irq});
            tick();
        end

        // Change arriving on the same edge as a W1C: the flag stays set.
        PortIn = 8'hA5;
        tick();
        tick();
        wr(B + 32'h8, 32'h1);
        read_check("w1c_vs_change", B + 32'h8, 32'h1);
        read_check("ecnt_two", B + 32'hC, 32'h2);

        // Change arriving on the same edge as an ECNT write: clear then count.
        PortIn = 8'h00;
        tick();
        tick();
        wr(B + 32'hC, 32'hFFFF_FFFF);
        read_check("ecnt_clr_vs_change", B + 32'hC, 32'h1);
        start_read(B + 32'hC);
        check("ecnt4_clr_vs_change", read_data4, 32'h1);
        tick();

        // Saturation: 20 changes; the 4-bit counter stops at 15, the 16-bit one reaches 20.
        wr(B + 32'hC, 32'h0);
        for (int t = 0; t < 20; t++) begin
            PortIn = ~PortIn;
            for (int c = 0; c < 4; c++) tick();
        end
        start_read(B + 32'hC);
        check("ecnt4_sat", read_data4, 32'hF);
        check("ecnt16_twenty", read_data, 32'd20);
        tick();
        wr(B + 32'hC, 32'h0);
        start_read(B + 32'hC);
        check("ecnt4_cleared", read_data4, 32'h0);
        check("ecnt16_cleared", read_data, 32'h0);
        tick();

        // Reset lands during a store to OUT; the store is lost.
        Address   = B;
        WriteData = 32'h0000_1234;
        MemWrite  = 1'b1;
        #2 reset = 1'b0;
        PortIn = 8'h01;
        @(negedge clk);
        check("midrst_portout", port_out, 32'h0);
        tick();
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        read_check("postrst_stat_edge2", B + 32'h8, 32'h0);
        read_check("postrst_stat_edge3", B + 32'h8, 32'h1);
        read_check("postrst_ecnt", B + 32'hC, 32'h1);
        read_check("postrst_out", B, 32'h0);
        check("postrst_portout", port_out, 32'h0);
        check("postrst_irq", {31'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
